// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared types and constants for the FIFO read-side streamer
package fifo_rd_pkg;

  localparam int RD_BUF_DEPTH   = 3;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BURST_LEN  = 4;

  typedef logic [1:0] rd_ptr_t;
  typedef logic [1:0] rd_cnt_t;

  localparam rd_cnt_t RD_CNT_FULL = 2'd3;

  // Pointers cover three slots only, so they wrap from 2 back to 0.
  function automatic rd_ptr_t rd_ptr_inc(input rd_ptr_t p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// rtl/rd_skid_buf.sv - 3-entry circular buffer absorbing the FIFO read latency
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Push,
  input  logic [DATA_WIDTH-1:0] i_Push_Data,
  input  logic                  i_Pop,
  output rd_cnt_t               o_Count,
  output logic [DATA_WIDTH-1:0] o_Head_Data
);

  logic [DATA_WIDTH-1:0] r_mem [RD_BUF_DEPTH];
  rd_ptr_t               r_wr_ptr;
  rd_ptr_t               r_rd_ptr;
  rd_cnt_t               r_count;
  logic                  w_push;
  logic                  w_pop;

  assign w_pop  = i_Pop && (r_count != 2'd0);
  // A push into a full buffer is dropped unless a pop frees a slot this cycle.
  assign w_push = i_Push && ((r_count != RD_CNT_FULL) || w_pop);

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < RD_BUF_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_Push_Data;
        r_wr_ptr        <= rd_ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= rd_ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_Count     = r_count;
  assign o_Head_Data = r_mem[r_rd_ptr];

endmodule

// File: rtl/fifo_rd_streamer.sv
// rtl/fifo_rd_streamer.sv - FIFO read master presenting a valid/ready burst stream
// Optional checker and assertions: FIFO_RD_STREAMER_CHECK_EN
module fifo_rd_streamer
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  output logic                  o_Rd_En,
  input  logic                  i_Empty,
  input  logic [DATA_WIDTH-1:0] i_Rd_Data,
  input  logic                  i_Data_Valid,
  output logic [DATA_WIDTH-1:0] o_Tdata,
  output logic                  o_Tvalid,
  input  logic                  i_Tready,
  output logic                  o_Tlast,
  output logic                  o_Err
);

  localparam int                BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  logic              r_inflight;
  logic [BEAT_W-1:0] r_beat;
  rd_cnt_t           w_count;
  logic [2:0]        w_occupancy;
  logic              w_push;
  logic              w_pop;

  rd_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Push      (w_push),
    .i_Push_Data (i_Rd_Data),
    .i_Pop       (w_pop),
    .o_Count     (w_count),
    .o_Head_Data (o_Tdata)
  );

  // Words already buffered plus the one possibly on its way must fit in three slots.
  assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight};
  assign o_Rd_En     = i_Reset && !i_Empty && (w_occupancy < 3'd3);
  assign o_Tvalid    = (w_count != 2'd0);
  assign o_Tlast     = o_Tvalid && (r_beat == BEAT_LAST);
  assign w_pop       = o_Tvalid && i_Tready;
  assign w_push      = i_Data_Valid && r_inflight;

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_inflight <= 1'b0;
      r_beat     <= '0;
    end else begin
      r_inflight <= o_Rd_En;
      if (w_pop) r_beat <= (r_beat == BEAT_LAST) ? '0 : r_beat + 1'b1;
    end
  end

`ifdef FIFO_RD_STREAMER_CHECK_EN
  logic r_err;

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_err <= 1'b0;
    end else if ((i_Data_Valid && !r_inflight) ||
                 (w_push && (w_count == RD_CNT_FULL) && !w_pop)) begin
      r_err <= 1'b1;
    end
  end

  assign o_Err = r_err;

  a_no_rd_when_empty: assert property (@(posedge i_Clk) disable iff (!i_Reset)
    !(o_Rd_En && i_Empty));
  a_hold_under_bp: assert property (@(posedge i_Clk) disable iff (!i_Reset)
    (o_Tvalid && !i_Tready) |=> ($stable(o_Tdata) && $stable(o_Tlast)));
  a_count_bound: assert property (@(posedge i_Clk) disable iff (!i_Reset)
    (w_count <= RD_CNT_FULL));
`else
  assign o_Err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb/tb_fifo_rd_streamer.sv - self-checking bench for fifo_rd_streamer
module tb_fifo_rd_streamer;

  localparam int DW = 8;
  localparam int BL = 4;
`ifdef FIFO_RD_STREAMER_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic          i_Clk;
  logic          i_Reset;
  logic          o_Rd_En;
  logic          i_Empty;
  logic [DW-1:0] i_Rd_Data;
  logic          i_Data_Valid;
  logic [DW-1:0] o_Tdata;
  logic          o_Tvalid;
  logic          i_Tready;
  logic          o_Tlast;
  logic          o_Err;

  fifo_rd_streamer #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .o_Rd_En      (o_Rd_En),
    .i_Empty      (i_Empty),
    .i_Rd_Data    (i_Rd_Data),
    .i_Data_Valid (i_Data_Valid),
    .o_Tdata      (o_Tdata),
    .o_Tvalid     (o_Tvalid),
    .i_Tready     (i_Tready),
    .o_Tlast      (o_Tlast),
    .o_Err        (o_Err)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  typedef struct packed {
    logic          empty;
    logic          dv;
    logic [DW-1:0] data;
    logic          rdy;
    logic          rd;
    logic          tv;
    logic [DW-1:0] td;
    logic          tl;
  } vec_t;

  vec_t          vecs [16];
  int            n_tests, n_fail;
  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q  [$];
  int            n_beats, n_issued, n_cyc, m_count, m_inflight;
  int            first_beat, last_beat, load_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    i_Reset = 1'b0; i_Data_Valid = 1'b0; i_Empty = 1'b1; i_Tready = 1'b0; i_Rd_Data = '0;
    fifo_q.delete(); exp_q.delete();
    n_beats = 0; n_issued = 0; m_count = 0; m_inflight = 0; first_beat = 0; last_beat = 0;
    repeat (2) @(posedge i_Clk);
    #1 i_Reset = 1'b1;
  endtask

  task automatic load(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + DW'(i));
      exp_q.push_back(base + DW'(i));
    end
    i_Empty  = 1'b0;
    load_cyc = n_cyc;
  endtask

  // One clock with the bench acting as the FIFO and the spec-level model checking outputs.
  task automatic tick();
    logic rd, pop, dv;
    #1;
    rd = o_Rd_En; pop = o_Tvalid && i_Tready; dv = i_Data_Valid;
    check("rd_en", o_Rd_En, !i_Empty && (m_count + m_inflight < 3));
    check("tvalid", o_Tvalid, m_count != 0);
    if (o_Tvalid) begin
      if (exp_q.size() == 0) check("beat_without_word", exp_q.size(), 1);
      else begin
        check("tdata", o_Tdata, exp_q[0]);
        check("tlast", o_Tlast, (n_beats % BL) == BL - 1);
      end
    end else begin
      check("tlast_idle", o_Tlast, 0);
    end
    @(posedge i_Clk);
    #1;
    if (pop) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (n_beats == 0) first_beat = n_cyc;
      last_beat = n_cyc;
      n_beats++;
    end
    if (rd && fifo_q.size() > 0) begin
      n_issued++;
      i_Rd_Data    = fifo_q.pop_front();
      i_Data_Valid = 1'b1;
    end else begin
      i_Data_Valid = 1'b0;
    end
    m_count    = m_count + (dv ? 1 : 0) - (pop ? 1 : 0);
    m_inflight = rd ? 1 : 0;
    i_Empty    = (fifo_q.size() == 0);
    check("occupancy", (n_issued - n_beats) <= 3, 1);
    n_cyc++;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; n_cyc = 0;
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 8'h04, 1'b1, 1'b0, 1'b1, 8'h03, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h04, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

    // Reset held with a non-empty FIFO and stray valid pulses.
    i_Reset = 1'b0; i_Empty = 1'b0; i_Tready = 1'b1; i_Rd_Data = 8'h3C; i_Data_Valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge i_Clk); #1;
      i_Data_Valid = ~i_Data_Valid;
      #1;
      check("rst_rd_en", o_Rd_En, 0);
      check("rst_tvalid", o_Tvalid, 0);
      check("rst_tlast", o_Tlast, 0);
      check("rst_err", o_Err, 0);
    end
    check("rst_tdata", o_Tdata, 0);
    i_Data_Valid = 1'b0; i_Empty = 1'b1;
    @(posedge i_Clk); #1 i_Reset = 1'b1;

    // Hand-driven FIFO: single word, then backpressure with pointer wrap.
    foreach (vecs[i]) begin
      i_Empty = vecs[i].empty; i_Data_Valid = vecs[i].dv;
      i_Rd_Data = vecs[i].data; i_Tready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d_rd_en", i), o_Rd_En, vecs[i].rd);
      check($sformatf("vec%0d_tvalid", i), o_Tvalid, vecs[i].tv);
      check($sformatf("vec%0d_tlast", i), o_Tlast, vecs[i].tl);
      if (vecs[i].tv) check($sformatf("vec%0d_tdata", i), o_Tdata, vecs[i].td);
      @(posedge i_Clk); #1;
    end

    // Single word latency.
    do_reset(); i_Tready = 1'b1;
    load(1, 8'hA5);
    repeat (6) tick();
    check("single_beats", n_beats, 1);
    check("single_reads", n_issued, 1);
    check("single_latency", first_beat - load_cyc, 2);

    // Eight-word stream at full rate.
    do_reset(); i_Tready = 1'b1;
    load(8, 8'h01);
    for (int c = 0; c < 40 && n_beats < 8; c++) tick();
    check("stream_beats", n_beats, 8);
    check("stream_latency", first_beat - load_cyc, 2);
    check("stream_gapless", last_beat - first_beat, 7);

    // Backpressure: exactly three reads, head held, then gapless resume.
    do_reset(); i_Tready = 1'b0;
    load(8, 8'h01);
    repeat (10) tick();
    check("bp_reads", n_issued, 3);
    check("bp_tvalid", o_Tvalid, 1);
    check("bp_tdata", o_Tdata, 8'h01);
    i_Tready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) tick();
    check("bp_beats", n_beats, 8);
    check("bp_gapless", last_beat - first_beat, 7);

    // FIFO runs dry after two words.
    do_reset(); i_Tready = 1'b1;
    load(2, 8'h11);
    repeat (8) tick();
    check("dry_reads", n_issued, 2);
    check("dry_beats", n_beats, 2);

    // Randomized traffic with bursts of backpressure.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (fifo_q.size() < 16 && $urandom_range(0, 2) != 0) begin
        logic [DW-1:0] w;
        w = DW'($urandom);
        fifo_q.push_back(w); exp_q.push_back(w);
        i_Empty = 1'b0;
      end
      i_Tready = (((c / 300) % 2) == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      tick();
    end
    i_Tready = 1'b1;
    for (int c = 0; c < 100 && (exp_q.size() > 0 || m_count != 0); c++) tick();
    check("rand_drained", exp_q.size(), 0);

    // Unsolicited data valid.
    do_reset(); i_Tready = 1'b1;
    i_Data_Valid = 1'b1; i_Rd_Data = 8'h5A;
    @(posedge i_Clk); #1;
    i_Data_Valid = 1'b0;
    check("err_set", o_Err, ERR_ON);
    check("err_no_beat", o_Tvalid, 0);
    repeat (3) @(posedge i_Clk);
    #1;
    check("err_sticky", o_Err, ERR_ON);
    check("err_no_beat_late", o_Tvalid, 0);

    // Reset mid-operation discards buffered words and ignores late data.
    do_reset(); i_Tready = 1'b0;
    load(3, 8'h40);
    repeat (4) tick();
    check("mid_tvalid_before", o_Tvalid, 1);
    #2 i_Reset = 1'b0;
    #1;
    check("mid_tvalid_rst", o_Tvalid, 0);
    check("mid_rd_en_rst", o_Rd_En, 0);
    check("mid_err_rst", o_Err, 0);
    @(posedge i_Clk); #1;
    i_Reset = 1'b1; i_Empty = 1'b1; i_Data_Valid = 1'b1; i_Rd_Data = 8'h77;
    @(posedge i_Clk); #1;
    i_Data_Valid = 1'b0;
    check("mid_stale_dropped", o_Tvalid, 0);
    check("mid_stale_err", o_Err, ERR_ON);
    @(posedge i_Clk); #1;
    check("mid_stale_dropped_late", o_Tvalid, 0);

    do_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_streamer.md
# fifo_rd_streamer

Read-side master for the synchronous FIFO. It pulls words from the FIFO read port and hides the FIFO's one-cycle read latency behind a 3-entry credit buffer. It presents the words downstream as a valid/ready stream, with a last marker generated every `BURST_LEN` beats. It sits between the FIFO's `o_Rd_Data`/`o_Data_Valid` outputs and any stream consumer.

## Interface
Parameters:
- `DATA_WIDTH`, 8: word width; must match the FIFO.
- `BURST_LEN`, 4: beats per burst for `o_Tlast`; must be ≥1.

Ports:
- `i_Clk` input 1: single clock; all logic uses the rising edge.
- `i_Reset` input 1: asynchronous, active-low reset.
- `o_Rd_En` output 1: read strobe to the FIFO `i_Rd_En`.
- `i_Empty` input 1: from the FIFO `o_Empty`.
- `i_Rd_Data` input `DATA_WIDTH`: from the FIFO `o_Rd_Data`.
- `i_Data_Valid` input 1: from the FIFO `o_Data_Valid`; it arrives one cycle after `o_Rd_En`.
- `o_Tdata` output `DATA_WIDTH`: stream data.
- `o_Tvalid` output 1: stream valid.
- `i_Tready` input 1: stream ready.
- `o_Tlast` output 1: marks the last beat of a burst.
- `o_Err` output 1: sticky protocol-error flag. It is always present; see Configuration.

## Operation
- Buffer state:
  - `count` (0..3) is the number of words held in the buffer.
  - `inflight` (0..1) is `o_Rd_En` registered by one cycle.
- Read issue: `o_Rd_En = !i_Empty && (count + inflight < 3)`. There is no combinational path from `i_Tready` to `o_Rd_En`.
- Push: when `i_Data_Valid=1`, write `i_Rd_Data` at the buffer tail.
- Pop: when `o_Tvalid && i_Tready`, advance the buffer head.
- Simultaneous push and pop leave `count` unchanged.
- Buffer pointers are 2 bits and wrap from 2 to 0.
- Stream outputs:
  - `o_Tvalid = (count != 0)`.
  - `o_Tdata` is the buffer head entry.
  - Words leave in FIFO order; none are dropped or duplicated.
- Hold rule: while `o_Tvalid=1` and `i_Tready=0`, `o_Tdata` and `o_Tlast` hold stable.
- Beat counter: width `max(1,$clog2(BURST_LEN))`.
  - It increments on each pop and wraps to 0 after `BURST_LEN-1`.
  - `o_Tlast = o_Tvalid && (beat == BURST_LEN-1)`.
  - With `BURST_LEN=1`, `o_Tlast` equals `o_Tvalid`.
- Empty boundary: `o_Rd_En` deasserts in the same cycle `i_Empty` rises. No read is ever issued while `i_Empty=1`.
- Full boundary: at `count + inflight = 3`, no reads are issued until a pop occurs. The buffer never overflows under correct FIFO behaviour.
- Reset values:
  - `o_Rd_En` is 0; it is gated low while `i_Reset=0`.
  - `o_Tvalid`, `o_Tdata`, `o_Tlast` and `o_Err` are 0.
  - `count`, `inflight`, both pointers and `beat` are 0.
- Reset mid-operation: all state clears immediately and buffered words are discarded. An `i_Data_Valid` that arrives after reset release with `inflight=0` is ignored and is not pushed.

## Timing
- Latency: `i_Empty` falls in cycle N, `o_Rd_En` is asserted in N, `i_Data_Valid` arrives in N+1, and `o_Tvalid` with the data appears in N+2.
- Throughput: one beat per cycle is sustained while the FIFO is non-empty and `i_Tready=1`.
- Backpressure: a maximum of 3 words are accepted from the FIFO after `i_Tready` drops.
- `o_Tvalid`, `o_Tdata`, `o_Tlast` and `o_Err` come from registered state only.

## Configuration
- `FIFO_RD_STREAMER_CHECK_EN` defined:
  - `o_Err` sets and stays 1 until reset on either condition:
    - `i_Data_Valid=1` while `inflight=0`.
    - A push while `count=3` with no pop.
  - The push is still suppressed in both cases.
  - Concurrent assertions are compiled in for three properties:
    - `!(o_Rd_En && i_Empty)`.
    - `o_Tdata` stability under backpressure.
    - `count <= 3`.
- Not defined: `o_Err` is tied to 0, no checker logic or assertions are present, and unexpected data is silently dropped.

## Structure
- Package `fifo_rd_pkg` holds the following:
  - Localparam `RD_BUF_DEPTH = 3`.
  - Typedef `rd_ptr_t` (2 bits).
  - Typedef `rd_cnt_t` (2 bits, 0..3).
  - Default `DATA_WIDTH`/`BURST_LEN` constants.
- Sub-module `rd_skid_buf`: the 3-entry circular buffer with push/pop, count and head data.
- Top level: issue logic, `inflight`, beat counter and the optional checker.

## Test plan
- Reset: hold `i_Reset=0` with `i_Empty=0` and `i_Data_Valid` toggling → `o_Rd_En`, `o_Tvalid`, `o_Tlast` and `o_Err` all stay 0.
- Single word: FIFO holds 0xA5 and `i_Tready=1` → one `o_Rd_En` pulse in cycle N, then `o_Tvalid=1` with `o_Tdata=0xA5` in N+2 for exactly one cycle.
- Stream: 8 words 0x01..0x08, `i_Tready=1`, `BURST_LEN=4` → 8 consecutive beats in order with `o_Tlast` on 0x04 and 0x08 only.
- Backpressure: FIFO full and `i_Tready=0` for 10 cycles → exactly 3 `o_Rd_En` pulses and `o_Tdata=0x01` held. On release, 0x01.. resume in order with no gaps or loss.
- Empty mid-stream: 2 words, then `i_Empty=1` → `o_Rd_En` low in the same cycle, 2 beats out and no further reads.
- Error (macro defined): inject `i_Data_Valid=1` with no outstanding read → `o_Err=1` next cycle and held until reset, with no beat emitted. With the macro undefined, `o_Err` stays 0.
